// File: rtl/thread_pc_controller.sv
// Round-robin per-thread PC sequencer: issues one thread's PC per cycle and applies the
// delayed re-issue/branch/increment decision. Define THREAD_PC_JUMP_PRIORITY_EN to take the lowest-index jump destination instead of OR-ing them.
module thread_pc_controller #(
  parameter int PC_WIDTH          = 10,
  parameter int THREAD_COUNT      = 8,
  parameter int THREAD_ADDR_WIDTH = 3,
  parameter int INITIAL_THREAD    = 0,
  parameter int BRANCH_COUNT      = 4,
  parameter int START_PC          = 0,
  parameter int UPDATE_OFFSET     = 6
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [BRANCH_COUNT-1:0]          jump_in,
  input  logic [BRANCH_COUNT*PC_WIDTH-1:0] branch_destination_in,
  input  logic                             IO_ready_previous,
  input  logic                             pc_wren,
  input  logic [THREAD_ADDR_WIDTH-1:0]     pc_write_thread,
  input  logic [PC_WIDTH-1:0]              pc_write_data,
  output logic [PC_WIDTH-1:0]              pc,
  output logic [THREAD_ADDR_WIDTH-1:0]     pc_thread,
  output logic                             jump_conflict
);

  localparam int TAW = THREAD_ADDR_WIDTH;
  localparam logic [TAW-1:0] LAST_THREAD   = TAW'(THREAD_COUNT - 1);
  localparam logic [TAW:0]   THREAD_COUNT_W = (TAW+1)'(THREAD_COUNT);
  localparam logic [TAW:0]   BACK_OFFSET    = (TAW+1)'(THREAD_COUNT - UPDATE_OFFSET);
  localparam logic [TAW:0]   WARM_DONE      = (TAW+1)'(UPDATE_OFFSET);

  logic [TAW-1:0]      issue_reg;
  logic [TAW-1:0]      issue_next;
  logic [TAW:0]        warm_reg;
  logic                update_en;
  logic [TAW:0]        update_sum;
  logic [TAW-1:0]      update_thread;
  logic [PC_WIDTH-1:0] pc_mem [THREAD_COUNT];
  logic [PC_WIDTH-1:0] dest_slice [BRANCH_COUNT];
  logic [PC_WIDTH-1:0] dest_sel;
  logic [PC_WIDTH-1:0] update_cur;
  logic [PC_WIDTH-1:0] update_next;
  logic                any_jump;
  logic                multi_jump;

  genvar gi;
  generate
    for (gi = 0; gi < BRANCH_COUNT; gi++) begin : g_slice
      assign dest_slice[gi] = branch_destination_in[gi*PC_WIDTH +: PC_WIDTH];
    end
  endgenerate

  assign issue_next = (issue_reg == LAST_THREAD) ? '0 : issue_reg + TAW'(1);

  // Thread being updated is the one issued UPDATE_OFFSET cycles ago; adding the
  // complement and folding once avoids a negative intermediate.
  assign update_sum    = {1'b0, issue_reg} + BACK_OFFSET;
  assign update_thread = (update_sum >= THREAD_COUNT_W) ? TAW'(update_sum - THREAD_COUNT_W)
                                                        : TAW'(update_sum);
  assign update_en     = (warm_reg == WARM_DONE);

  assign any_jump   = |jump_in;
  assign multi_jump = (jump_in & (jump_in - BRANCH_COUNT'(1))) != '0;

`ifdef THREAD_PC_JUMP_PRIORITY_EN
  always_comb begin
    dest_sel = '0;
    for (int i = BRANCH_COUNT - 1; i >= 0; i--) begin
      if (jump_in[i]) dest_sel = dest_slice[i];
    end
  end
`else
  // Non-jumping instances drive zero, so a plain OR yields the taken destination.
  always_comb begin
    dest_sel = '0;
    for (int i = 0; i < BRANCH_COUNT; i++) begin
      dest_sel = dest_sel | dest_slice[i];
    end
  end
`endif

  assign update_cur = pc_mem[update_thread];

  always_comb begin
    update_next = update_cur + PC_WIDTH'(1);
    if (!IO_ready_previous) begin
      update_next = update_cur;
    end else if (any_jump) begin
      update_next = dest_sel;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      issue_reg     <= TAW'(INITIAL_THREAD);
      warm_reg      <= '0;
      pc            <= '0;
      pc_thread     <= '0;
      jump_conflict <= 1'b0;
      for (int i = 0; i < THREAD_COUNT; i++) begin
        pc_mem[i] <= PC_WIDTH'(START_PC);
      end
    end else begin
      issue_reg     <= issue_next;
      pc            <= pc_mem[issue_reg];
      pc_thread     <= issue_reg;
      jump_conflict <= update_en && multi_jump;
      if (!update_en) begin
        warm_reg <= warm_reg + (TAW+1)'(1);
      end
      if (update_en) begin
        pc_mem[update_thread] <= update_next;
      end
      // Later assignment wins, so an external write to the update thread overrides it.
      if (pc_wren && (pc_write_thread <= LAST_THREAD)) begin
        pc_mem[pc_write_thread] <= pc_write_data;
      end
    end
  end

endmodule

// File: tb/tb_thread_pc_controller.sv
// Scoreboard bench for thread_pc_controller: a per-thread PC array model predicts each
// issued PC; a monitor pops and compares every cycle.
module tb_thread_pc_controller;
  localparam int PW = 10, T = 8, TAW = 3, INIT = 0, BC = 4, START = 0, OFF = 6;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [BC-1:0]     jump_in = '0;
  logic [BC*PW-1:0]  branch_destination_in = '0;
  logic              IO_ready_previous = 1'b1;
  logic              pc_wren = 1'b0;
  logic [TAW-1:0]    pc_write_thread = '0;
  logic [PW-1:0]     pc_write_data = '0;
  logic [PW-1:0]     pc;
  logic [TAW-1:0]    pc_thread;
  logic              jump_conflict;

  thread_pc_controller #(
    .PC_WIDTH(PW), .THREAD_COUNT(T), .THREAD_ADDR_WIDTH(TAW), .INITIAL_THREAD(INIT),
    .BRANCH_COUNT(BC), .START_PC(START), .UPDATE_OFFSET(OFF)
  ) dut (
    .clock(clock), .reset(reset), .jump_in(jump_in),
    .branch_destination_in(branch_destination_in), .IO_ready_previous(IO_ready_previous),
    .pc_wren(pc_wren), .pc_write_thread(pc_write_thread), .pc_write_data(pc_write_data),
    .pc(pc), .pc_thread(pc_thread), .jump_conflict(jump_conflict)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [PW-1:0]  pc;
    logic [TAW-1:0] th;
    logic           cf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_txn = 0;

  // Reference model: PC per thread, cycles since reset, and the threads issued so far
  // whose decision has not yet arrived.
  int m_pc[T];
  int hist[$];
  int k;

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_txn++;
        $display("txn %0d: pc=%h thread=%0d conflict=%b (want %h/%0d/%b)",
                 n_txn, pc, pc_thread, jump_conflict, e.pc, e.th, e.cf);
        n_checks++;
        if (pc !== e.pc) begin
          n_fail++;
          $display("FAIL pc txn %0d: got %h expected %h", n_txn, pc, e.pc);
        end
        n_checks++;
        if (pc_thread !== e.th) begin
          n_fail++;
          $display("FAIL pc_thread txn %0d: got %0d expected %0d", n_txn, pc_thread, e.th);
        end
        n_checks++;
        if (jump_conflict !== e.cf) begin
          n_fail++;
          $display("FAIL jump_conflict txn %0d: got %b expected %b", n_txn, jump_conflict, e.cf);
        end
      end
    end
  end

  function automatic int model_dest(logic [BC-1:0] j, logic [BC*PW-1:0] d);
    int r = 0;
`ifdef THREAD_PC_JUMP_PRIORITY_EN
    for (int i = 0; i < BC; i++) begin
      if (j[i]) return int'(d[i*PW +: PW]);
    end
`else
    for (int i = 0; i < BC; i++) begin
      if (j[i]) r = r | int'(d[i*PW +: PW]);
    end
`endif
    return r;
  endfunction

  // Thread whose decision is consumed in the next step, or -1 during warm-up.
  function automatic int peek_u();
    if (hist.size() == OFF) return hist[0];
    return -1;
  endfunction

  task automatic do_reset();
    exp_t e;
    @(negedge clock);
    reset = 1'b1;
    jump_in = '0;
    branch_destination_in = '0;
    IO_ready_previous = 1'b1;
    pc_wren = 1'b0;
    for (int i = 0; i < T; i++) m_pc[i] = START;
    hist.delete();
    k = 0;
    e.pc = '0; e.th = '0; e.cf = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [BC-1:0] j, input logic [BC*PW-1:0] d, input logic io,
                      input logic we, input int wt, input int wd);
    exp_t e;
    int   issued;
    int   u;
    @(negedge clock);
    reset = 1'b0;
    jump_in = j;
    branch_destination_in = d;
    IO_ready_previous = io;
    pc_wren = we;
    pc_write_thread = TAW'(wt);
    pc_write_data = PW'(wd);
    issued = (INIT + k) % T;
    e.pc = PW'(m_pc[issued]);
    e.th = TAW'(issued);
    e.cf = 1'b0;
    hist.push_back(issued);
    if (hist.size() > OFF) begin
      u = hist.pop_front();
      e.cf = ($countones(j) > 1);
      if (io) begin
        if (j != '0) m_pc[u] = model_dest(j, d);
        else m_pc[u] = (m_pc[u] + 1) % (1 << PW);
      end
    end
    if (we) m_pc[wt] = wd;
    exp_q.push_back(e);
    k++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic until_u(input int t);
    int guard = 0;
    while (peek_u() != t && guard < 2 * T + OFF) begin
      idle(1);
      guard++;
    end
    n_checks++;
    if (peek_u() != t) begin
      n_fail++;
      $display("FAIL until_u: update thread %0d expected %0d", peek_u(), t);
    end
  endtask

  initial begin
    logic [BC*PW-1:0] d;
    logic [BC-1:0]    j;
    do_reset();
    // Inputs during warm-up must be ignored, conflict included.
    d = '0; d[0 +: PW] = 10'h111; d[PW +: PW] = 10'h222;
    step(4'b0011, d, 1'b1, 1'b0, 0, 0);
    step(4'b0011, d, 1'b1, 1'b0, 0, 0);
    idle(30);

    until_u(3);
    d = '0; d[0 +: PW] = 10'h155;
    step(4'b0001, d, 1'b1, 1'b0, 0, 0);
    idle(20);

    until_u(5);
    d = '0; d[PW +: PW] = 10'h020;
    step(4'b0010, d, 1'b0, 1'b0, 0, 0);
    idle(20);

    until_u(1);
    step('0, '0, 1'b1, 1'b1, 2, 10'h3FF);
    idle(20);

    until_u(4);
    d = '0; d[0 +: PW] = 10'h155;
    step(4'b0001, d, 1'b1, 1'b1, 4, 10'h0AA);
    idle(20);

    until_u(6);
    d = '0; d[PW +: PW] = 10'h010; d[2*PW +: PW] = 10'h004;
    step(4'b0110, d, 1'b1, 1'b0, 0, 0);
    idle(20);

    // External write to the thread being issued this cycle must not affect this issue.
    step('0, '0, 1'b1, 1'b1, (INIT + k) % T, 10'h123);
    idle(12);

    do_reset();
    idle(10);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      j = '0;
      d = '0;
      for (int i = 0; i < BC; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          j[i] = 1'b1;
          d[i*PW +: PW] = PW'($urandom);
        end
      end
      step(j, d, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, T - 1), $urandom_range(0, (1 << PW) - 1));
    end

    repeat (3) @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected outputs left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
